// File: rtl/rst_tracker.sv
// Register status table: per-register busy flag plus producer FU tag, set by dispatch,
// cleared by tag-matching writebacks, with two combinational source lookups.
module rst_tracker #(
   parameter int NREGS   = 32,
   parameter int TAG_W   = 2,
   parameter int NWB     = 2,
   parameter int ZERO_HW = 1,
   parameter int WB_BYP  = 1,
   localparam int IDX_W  = $clog2(NREGS)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   flush,
   input  logic                   di_en,
   input  logic [IDX_W-1:0]       di_rd,
   input  logic [TAG_W-1:0]       di_tag,
   input  logic [2*IDX_W-1:0]     rs_idx,
   output logic [1:0]             rs_busy,
   output logic [2*TAG_W-1:0]     rs_tag,
   input  logic [NWB-1:0]         wb_en,
   input  logic [NWB*IDX_W-1:0]   wb_rd,
   input  logic [NWB*TAG_W-1:0]   wb_tag,
   output logic [NREGS-1:0]       busy_vec,
   output logic [IDX_W:0]         busy_cnt,
   output logic                   all_idle
);

   logic [NREGS-1:0]            busy_q, busy_d;
   logic [NREGS-1:0][TAG_W-1:0] tag_q, tag_d;
   logic [IDX_W:0]              cnt_q, cnt_d;
   logic                        idle_q;
   logic [NREGS-1:0]            clr;
   logic [IDX_W-1:0]            srcIdx;

   // A writeback only clears the entry if it still belongs to that producer, so a newer
   // (re-dispatched) owner survives. Dispatch overrides any same-cycle clear; flush overrides all.
   always_comb begin
      clr    = '0;
      busy_d = busy_q;
      tag_d  = tag_q;
      cnt_d  = '0;
      for (int r = 0; r < NREGS; r++) begin
         for (int k = 0; k < NWB; k++) begin
            if (wb_en[k] && wb_rd[k*IDX_W +: IDX_W] == IDX_W'(r) && busy_q[r] &&
                tag_q[r] == wb_tag[k*TAG_W +: TAG_W])
               clr[r] = 1'b1;
         end
      end
      for (int r = 0; r < NREGS; r++) begin
         if (di_en && di_rd == IDX_W'(r) && !(ZERO_HW != 0 && r == 0)) begin
            busy_d[r] = 1'b1;
            tag_d[r]  = di_tag;
         end else if (clr[r]) begin
            busy_d[r] = 1'b0;
            tag_d[r]  = '0;
         end
      end
      if (flush) begin
         busy_d = '0;
         tag_d  = '0;
      end
      for (int r = 0; r < NREGS; r++)
         cnt_d = cnt_d + (IDX_W+1)'(busy_d[r]);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         busy_q <= '0;
         tag_q  <= '0;
         cnt_q  <= '0;
         idle_q <= 1'b1;
      end else begin
         busy_q <= busy_d;
         tag_q  <= tag_d;
         cnt_q  <= cnt_d;
         idle_q <= (cnt_d == '0);
      end
   end

   // Lookups see registered state only; with bypass a same-cycle matching clear reads as idle.
   always_comb begin
      rs_busy = '0;
      rs_tag  = '0;
      srcIdx  = '0;
      for (int s = 0; s < 2; s++) begin
         srcIdx = rs_idx[s*IDX_W +: IDX_W];
         for (int r = 0; r < NREGS; r++) begin
            if (srcIdx == IDX_W'(r) && busy_q[r] && !(WB_BYP != 0 && clr[r])) begin
               rs_busy[s]                = 1'b1;
               rs_tag[s*TAG_W +: TAG_W]  = tag_q[r];
            end
         end
      end
   end

   assign busy_vec = busy_q;
   assign busy_cnt = cnt_q;
   assign all_idle = idle_q;

endmodule
